flappy_game_ctrl: RTL and testbench

- Game-level sequencer for the Flappy Bird datapath.
- Runs the IDLE/RUN/DEAD game FSM and owns the three pipe slots: positions, scrolling, respawn, and pseudo-random gap heights.
- Feeds pipe coordinates to the collision detector, consumes its game_over pulse and score, clears it between games, and keeps a high score.
- Sits between the frame-tick generator / button input and the collision detector plus renderer.

---
 rtl/flappy_game_ctrl_pkg.sv | 26 ++
 rtl/flappy_game_ctrl_pipe_slot.sv | 43 ++++
 rtl/flappy_game_ctrl.sv | 129 ++++++++++++
 tb/tb_flappy_game_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_game_ctrl_pkg.sv
// Shared types and constants for the Flappy Bird game sequencer.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } game_state_t;

  localparam int unsigned PIPE_W = 11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic [PIPE_W-1:0] x;
    logic [PIPE_W-1:0] y0;
    logic [PIPE_W-1:0] y1;
  } pipe_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/flappy_game_ctrl_pipe_slot.sv
// One pipe's position and gap registers: reload, scroll and respawn.
module pipe_slot #(
  parameter int unsigned N         = 11,
  parameter int unsigned START_X   = 640,
  parameter int unsigned RESPAWN_X = 648,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned GAP       = 120,
  parameter int unsigned Y1_START  = 164
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] respawn_y1,
  output logic [N-1:0] x,
  output logic [N-1:0] y0,
  output logic [N-1:0] y1
);

  localparam logic [N-1:0] X_INIT  = N'(START_X);
  localparam logic [N-1:0] X_RESP  = N'(RESPAWN_X);
  localparam logic [N-1:0] X_STEP  = N'(SPEED);
  localparam logic [N-1:0] GAP_N   = N'(GAP);
  localparam logic [N-1:0] Y1_INIT = N'(Y1_START);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      x  <= X_INIT;
      y1 <= Y1_INIT;
      y0 <= Y1_INIT + GAP_N;
    end else if (step) begin
      // Respawn check precedes the subtract, so x never wraps below zero
      if (x == '0) begin
        x  <= X_RESP;
        y1 <= respawn_y1;
        y0 <= respawn_y1 + GAP_N;
      end else begin
        x <= x - X_STEP;
      end
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-level sequencer: IDLE/RUN/DEAD FSM, three pipe slots, gap LFSR, high score.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned N            = PIPE_W,
  parameter int unsigned START_X      = 640,
  parameter int unsigned PIPE_SPACING = 216,
  parameter int unsigned SPEED        = 4,
  parameter int unsigned GAP          = 120,
  parameter int unsigned GAP_BASE     = 100,
  parameter int unsigned DEAD_TICKS   = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         flap_btn,
  input  logic         collision,
  input  logic [6:0]   score,
  output logic [N-1:0] pipe1_x,
  output logic [N-1:0] pipe2_x,
  output logic [N-1:0] pipe3_x,
  output logic [N-1:0] pipe1_y0,
  output logic [N-1:0] pipe2_y0,
  output logic [N-1:0] pipe3_y0,
  output logic [N-1:0] pipe1_y1,
  output logic [N-1:0] pipe2_y1,
  output logic [N-1:0] pipe3_y1,
  output logic [1:0]   state,
  output logic         det_reset,
  output logic [6:0]   high_score
);

  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

  game_state_t   st;
  logic          btn_q;
  logic [7:0]    lfsr;
  logic [DW-1:0] dead_cnt;

  logic          flap_rise;
  logic          dead_last;
  logic          load_start;
  logic          step;
  logic [N-1:0]  respawn_y1;
  pipe_t         pipes [3];

  always_comb begin
    flap_rise  = flap_btn & ~btn_q;
    dead_last  = (st == DEAD) && tick && (dead_cnt == DEAD_LAST);
    load_start = (st == IDLE) || dead_last;
    step       = (st == RUN) && tick && !collision;
    respawn_y1 = N'(GAP_BASE) + N'(lfsr[6:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      btn_q      <= 1'b0;
      lfsr       <= LFSR_SEED;
      dead_cnt   <= '0;
      high_score <= '0;
      det_reset  <= 1'b1;
    end else begin
      btn_q <= flap_btn;
      lfsr  <= lfsr_next(lfsr);
      case (st)
        IDLE: begin
          if (flap_rise) begin
            st        <= RUN;
            det_reset <= 1'b0;
          end
        end
        RUN: begin
          if (collision) begin
            st       <= DEAD;
            dead_cnt <= '0;
            if (score > high_score) high_score <= score;
          end
        end
        DEAD: begin
          if (dead_last) begin
            st        <= IDLE;
            det_reset <= 1'b1;
            dead_cnt  <= '0;
          end else if (tick) begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: begin
          st        <= IDLE;
          det_reset <= 1'b1;
        end
      endcase
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_pipe
    pipe_slot #(
      .N         (N),
      .START_X   (START_X + k * PIPE_SPACING),
      .RESPAWN_X (3 * PIPE_SPACING),
      .SPEED     (SPEED),
      .GAP       (GAP),
      .Y1_START  (GAP_BASE + 64)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (load_start),
      .step       (step),
      .respawn_y1 (respawn_y1),
      .x          (pipes[k].x),
      .y0         (pipes[k].y0),
      .y1         (pipes[k].y1)
    );
  end

  assign state    = st;
  assign pipe1_x  = pipes[0].x;
  assign pipe2_x  = pipes[1].x;
  assign pipe3_x  = pipes[2].x;
  assign pipe1_y0 = pipes[0].y0;
  assign pipe2_y0 = pipes[1].y0;
  assign pipe3_y0 = pipes[2].y0;
  assign pipe1_y1 = pipes[0].y1;
  assign pipe2_y1 = pipes[1].y1;
  assign pipe3_y1 = pipes[2].y1;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with hand-computed expectations.
module tb_flappy_game_ctrl;

  logic        clk = 1'b0;
  logic        reset, tick, flap_btn, collision;
  logic [6:0]  score;
  logic [10:0] pipe1_x, pipe2_x, pipe3_x;
  logic [10:0] pipe1_y0, pipe2_y0, pipe3_y0;
  logic [10:0] pipe1_y1, pipe2_y1, pipe3_y1;
  logic [1:0]  state;
  logic        det_reset;
  logic [6:0]  high_score;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  m_lfsr;
  int unsigned exp_y1;

  flappy_game_ctrl #(
    .N            (11),
    .START_X      (640),
    .PIPE_SPACING (216),
    .SPEED        (4),
    .GAP          (120),
    .GAP_BASE     (100),
    .DEAD_TICKS   (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .flap_btn   (flap_btn),
    .collision  (collision),
    .score      (score),
    .pipe1_x    (pipe1_x),
    .pipe2_x    (pipe2_x),
    .pipe3_x    (pipe3_x),
    .pipe1_y0   (pipe1_y0),
    .pipe2_y0   (pipe2_y0),
    .pipe3_y0   (pipe3_y0),
    .pipe1_y1   (pipe1_y1),
    .pipe2_y1   (pipe2_y1),
    .pipe3_y1   (pipe3_y1),
    .state      (state),
    .det_reset  (det_reset),
    .high_score (high_score)
  );

  always #5 clk = ~clk;

  // Reference gap generator: x^8+x^6+x^5+x^4+1, seeded 8'hA5, stepping every clk
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic flap_pulse();
    @(negedge clk) flap_btn = 1'b1;
    @(negedge clk) flap_btn = 1'b0;
  endtask

  task automatic collide(input logic [6:0] s, input logic with_tick);
    @(negedge clk);
    collision = 1'b1;
    score     = s;
    tick      = with_tick;
    @(negedge clk);
    collision = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic check_start(input string tag);
    check({tag, "_p1x"}, pipe1_x, 640);
    check({tag, "_p2x"}, pipe2_x, 856);
    check({tag, "_p3x"}, pipe3_x, 1072);
    check({tag, "_p1y1"}, pipe1_y1, 164);
    check({tag, "_p3y0"}, pipe3_y0, 284);
  endtask

  task automatic run_to_respawn(input string tag);
    ticks(160);
    check({tag, "_p1x_zero"}, pipe1_x, 0);
    check({tag, "_p2x_216"}, pipe2_x, 216);
    check({tag, "_p3x_432"}, pipe3_x, 432);
    @(negedge clk);
    tick   = 1'b1;
    exp_y1 = 100 + int'(m_lfsr[6:0]);
    @(negedge clk) tick = 1'b0;
    check({tag, "_resp_x"}, pipe1_x, 648);
    check({tag, "_resp_y1"}, pipe1_y1, exp_y1);
    check({tag, "_resp_y0"}, pipe1_y0, exp_y1 + 120);
    check({tag, "_resp_y1_range"}, int'(pipe1_y1 >= 100 && pipe1_y1 <= 227), 1);
    check({tag, "_resp_p2x"}, pipe2_x, 212);
    check({tag, "_resp_p3x"}, pipe3_x, 428);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; flap_btn = 1'b0; collision = 1'b0; score = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    ticks(25);
    check("idle_state", state, 0);
    check("idle_det_reset", det_reset, 1);
    check("idle_high", high_score, 0);
    check_start("idle");

    collide(7'd50, 1'b0);
    check("idle_coll_state", state, 0);
    check("idle_coll_high", high_score, 0);

    // Game 1: button held; only one rising edge
    @(negedge clk) flap_btn = 1'b1;
    repeat (20) @(negedge clk);
    flap_btn = 1'b0;
    check("g1_state_run", state, 1);
    check("g1_det_reset", det_reset, 0);
    check_start("g1_run_no_tick");
    ticks(3);
    check("g1_p1x_3t", pipe1_x, 628);
    check("g1_p2x_3t", pipe2_x, 844);
    check("g1_p3x_3t", pipe3_x, 1060);
    ticks(157);
    check("g1_p1x_zero", pipe1_x, 0);
    @(negedge clk);
    tick   = 1'b1;
    exp_y1 = 100 + int'(m_lfsr[6:0]);
    @(negedge clk) tick = 1'b0;
    check("g1_resp_x", pipe1_x, 648);
    check("g1_resp_y1", pipe1_y1, exp_y1);
    check("g1_resp_y0", pipe1_y0, exp_y1 + 120);
    check("g1_resp_range", int'(pipe1_y1 >= 100 && pipe1_y1 <= 227), 1);
    check("g1_resp_p2x", pipe2_x, 212);
    check("g1_resp_p3x", pipe3_x, 428);

    collide(7'd3, 1'b0);
    check("g1_dead_state", state, 2);
    check("g1_high", high_score, 3);
    check("g1_dead_det_reset", det_reset, 0);

    ticks(10);
    flap_pulse();
    collide(7'd99, 1'b0);
    ticks(13);
    check("g1_dead23_state", state, 2);
    check("g1_dead23_p1x", pipe1_x, 648);
    check("g1_dead23_high", high_score, 3);
    ticks(1);
    check("g1_dead24_state", state, 0);
    check("g1_dead24_det_reset", det_reset, 1);
    check_start("g1_reload");

    // Game 2: collision and tick together
    flap_pulse();
    check("g2_state_run", state, 1);
    ticks(2);
    check("g2_p1x", pipe1_x, 632);
    collide(7'd5, 1'b1);
    check("g2_dead_state", state, 2);
    check("g2_p1x_frozen", pipe1_x, 632);
    check("g2_p2x_frozen", pipe2_x, 848);
    check("g2_high", high_score, 5);
    ticks(24);
    check("g2_idle", state, 0);

    // Game 3: lower score leaves the high score alone
    flap_pulse();
    collide(7'd2, 1'b0);
    check("g3_dead_state", state, 2);
    check("g3_high", high_score, 5);
    ticks(24);
    check("g3_idle", state, 0);

    // Game 4: reset in mid-run
    flap_pulse();
    ticks(85);
    check("g4_p1x_300", pipe1_x, 300);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("g4_rst_state", state, 0);
    check("g4_rst_p1x", pipe1_x, 640);
    check("g4_rst_high", high_score, 0);
    check("g4_rst_det_reset", det_reset, 1);
    reset = 1'b0;

    // Post-reset respawn gap confirms the generator restarted from its seed
    flap_pulse();
    check("g5_state_run", state, 1);
    run_to_respawn("g5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
